// File: rtl/case_2_sdiv_5s_5s_5_seq.sv
//==============================================================================
// Module      : case_2_sdiv_5s_5s_5_seq
// Description : Sequential signed divider. Quotient truncates toward zero and
//               the remainder takes the sign of the dividend. It uses a
//               restoring shift-subtract loop that produces one quotient bit
//               per clock. The loop is followed by one sign-correction cycle
//               and a one-cycle done pulse.
//               Optional macro CASE_2_SDIV_DIVZERO_FLAG_EN adds a registered
//               div_by_zero output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module case_2_sdiv_5s_5s_5_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 5,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 5
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
`ifdef CASE_2_SDIV_DIVZERO_FLAG_EN
  output logic                  div_by_zero,
`endif
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem
);

  localparam int N  = din0_WIDTH;
  localparam int P  = N + 1;              // partial remainder width
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(N - 1);
  localparam logic [CW-1:0] C_N    = CW'(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  logic [N-1:0]          r_dvd;   // |dividend|, shifted out MSB first
  logic [P-1:0]          r_dvs;   // |divisor|
  logic [N-1:0]          r_num;   // raw dividend, for sign and div-by-zero
  logic                  r_qneg;
  logic [P-1:0]          r_part;
  logic [N-1:0]          r_quo;
  logic [CW-1:0]         r_cnt;

  // Magnitudes: the N-bit unsigned negation of -2^(N-1) is exactly 2^(N-1).
  logic [N-1:0]          w_a_abs;
  logic [din1_WIDTH-1:0] w_b_abs;
  logic [P:0]            w_shift;
  logic [P:0]            w_sub;
  logic                  w_ge;
  logic [P-1:0]          w_part_nx;
  logic                  w_dvs_zero;
  logic [N-1:0]          w_q_fix;
  logic [din1_WIDTH-1:0] w_r_mag;
  logic [din1_WIDTH-1:0] w_r_fix;
  logic [dout_WIDTH-1:0] w_dout_nx;
  logic [din1_WIDTH-1:0] w_rem_nx;
  logic                  w_unused;

  assign w_a_abs    = din0[N-1] ? (~din0 + 1'b1) : din0;
  assign w_b_abs    = din1[din1_WIDTH-1] ? (~din1 + 1'b1) : din1;

  // One restoring step: bring in the next dividend bit, subtract if it fits.
  assign w_shift    = {r_part, r_dvd[N-1]};
  assign w_sub      = w_shift - {1'b0, r_dvs};
  assign w_ge       = (w_shift >= {1'b0, r_dvs});
  assign w_part_nx  = w_ge ? w_sub[P-1:0] : w_shift[P-1:0];

  // Sign correction applied on the way into DONE.
  assign w_dvs_zero = (r_dvs == '0);
  assign w_q_fix    = r_qneg ? (~r_quo + 1'b1) : r_quo;
  assign w_r_mag    = r_part[din1_WIDTH-1:0];
  assign w_r_fix    = r_num[N-1] ? (~w_r_mag + 1'b1) : w_r_mag;
  assign w_dout_nx  = w_dvs_zero ? {dout_WIDTH{1'b1}} : dout_WIDTH'(w_q_fix);
  assign w_rem_nx   = w_dvs_zero ? r_num[din1_WIDTH-1:0] : w_r_fix;

  assign w_unused   = ^{w_sub[P], ID[0]};

  // Control FSM with the datapath registers and registered outputs.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_num       <= '0;
      r_qneg      <= 1'b0;
      r_part      <= '0;
      r_quo       <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      dout        <= '0;
      rem         <= '0;
`ifdef CASE_2_SDIV_DIVZERO_FLAG_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            r_dvd   <= w_a_abs;
            r_dvs   <= P'(w_b_abs);
            r_num   <= din0;
            r_qneg  <= din0[N-1] ^ din1[din1_WIDTH-1];
            r_part  <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          if (r_cnt != C_N) begin
            r_part <= w_part_nx;
            r_quo  <= {r_quo[N-2:0], w_ge};
            r_dvd  <= {r_dvd[N-2:0], 1'b0};
            r_cnt  <= r_cnt + 1'b1;
            // The last iteration ends the busy window; one finalize cycle follows.
            if (r_cnt == C_LAST) begin
              busy <= 1'b0;
            end
          end else begin
            dout        <= w_dout_nx;
            rem         <= w_rem_nx;
`ifdef CASE_2_SDIV_DIVZERO_FLAG_EN
            div_by_zero <= w_dvs_zero;
`endif
            done        <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
